umul_laccp_q: RTL

UMUL_LACCP_Q -- requirements
Module: umul_laccp_q

---
 rtl/umul_laccp_q_if.sv | 27 ++
 rtl/umul_laccp_q.sv | 122 ++++++++++++
 2 files changed

// File: rtl/umul_laccp_q_if.sv
// Operand/result bundle for the iterative unsigned fixed-point multiplier.
interface umul_laccp_q_if #(
  parameter int DW = 16,
  parameter int QI = 16,
  parameter int QF = 8,
  parameter int OW = 24
);
  logic          start;
  logic [DW-1:0] multiplicand;
  logic [QI-1:0] q_int;
  logic [QF-1:0] q_frac;
  logic          busy;
  logic          valid;
  logic          overflow;
  logic [OW-1:0] product;
  logic [QF-1:0] product_frac;

  modport master (
    output start, multiplicand, q_int, q_frac,
    input  busy, valid, overflow, product, product_frac
  );

  modport slave (
    input  start, multiplicand, q_int, q_frac,
    output busy, valid, overflow, product, product_frac
  );
endinterface

// File: rtl/umul_laccp_q.sv
// Unsigned integer x unsigned QI.QF multiplier, shift-add one multiplier bit
// per cycle (LSB first). Integer result optionally rounded and saturated to OW
// bits; fractional result always truncated.
module umul_laccp_q #(
  parameter int DW    = 16,
  parameter int QI    = 16,
  parameter int QF    = 8,
  parameter int OW    = 24,
  parameter int ROUND = 0
) (
  input  logic           clk,
  input  logic           rst,
  umul_laccp_q_if.slave  bus
);
  localparam int QW = QI + QF;
  localparam int PW = DW + QW;
  localparam int CW = $clog2(QW + 1);
  localparam int IW = DW + QI + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [QW-1:0] mplr_q, mplr_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [OW-1:0] prod_q, prod_d;
  logic [QF-1:0] frac_q, frac_d;

  logic [DW-1:0] addend;
  logic [DW:0]   sum;
  logic [PW-1:0] acc_step;
  logic          rnd_bit;
  logic [IW-1:0] int_full;
  logic          ovf_next;
  logic [OW-1:0] prod_next;

  // One shift-add step on the upper accumulator half, plus rounding and
  // saturation of the step result (used only on the last bit).
  // The adder carry becomes the new MSB, so after QW steps acc holds the
  // exact DW+QW-bit product with no extra width.
  always_comb begin
    addend    = mplr_q[0] ? mcand_q : '0;
    sum       = {1'b0, acc_q[PW-1:QW]} + {1'b0, addend};
    acc_step  = {sum, acc_q[QW-1:1]};
    rnd_bit   = (ROUND != 0) ? acc_step[QF-1] : 1'b0;
    int_full  = {1'b0, acc_step[PW-1:QF]} + {{(IW-1){1'b0}}, rnd_bit};
    ovf_next  = |(int_full >> OW);
    prod_next = ovf_next ? '1 : int_full[OW-1:0];
  end

  // Control: IDLE accepts start and loads operands; RUN processes one bit per
  // edge and issues valid with the registered result on the last bit.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    prod_d  = prod_q;
    frac_d  = frac_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mcand_d = bus.multiplicand;
          mplr_d  = {bus.q_int, bus.q_frac};
          acc_d   = '0;
          cnt_d   = CW'(QW);
        end
      end
      S_RUN: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          ovf_d   = ovf_next;
          prod_d  = prod_next;
          frac_d  = acc_step[QF-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      prod_q  <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      prod_q  <= prod_d;
      frac_q  <= frac_d;
    end
  end

  assign bus.busy         = (state_q == S_RUN);
  assign bus.valid        = valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.product      = prod_q;
  assign bus.product_frac = frac_q;
endmodule
